pc_redirect_sequencer: RTL and testbench
========================================

Name: pc_redirect_sequencer

Overview:
- Owns the program counter and selects the next PC each cycle: sequential PC+4, conditional branch, J/JAL, or JR.
- Computes branch targets as base + (sign-extended 16-bit offset << 2) and jump targets as {base[31:28], index << 2}.
- Issues a registered flush window to the IF/ID stages after every redirect.
- Sits between the instruction-fetch PC register and the ID/EX branch/jump resolution logic.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 1, number of cycles Flush stays high after a redirect; legal range 1..7.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Stall  input  1  hazard unit hold request; freezes PC when no redirect is taken.
- BranchTaken  input  1  resolved conditional branch is taken this cycle.
- BranchBase  input  32  PC+4 of the branch instruction.
- BranchOffset  input  16  raw immediate of the branch instruction.
- Jump  input  1  J/JAL decoded this cycle.
- JumpBase  input  32  PC+4 of the jump instruction.
- JumpIndex  input  26  instr_index field of the jump.
- JumpReg  input  1  JR/JALR resolved this cycle.
- JumpRegTarget  input  32  register-file target for JR.
- PCResult  output  32  current PC (fetch address).
- PCAddResult  output  32  PCResult + 4, combinational from PCResult.
- Flush  output  1  kill younger instructions in IF/ID.
- MisalignErr  output  1  sticky flag: a JR target had nonzero bits [1:0].

Behaviour:
- Reset (synchronous, sampled at the rising edge of Clk):
  - PCResult = RESET_PC, Flush = 0, MisalignErr = 0.
  - State = RUN, flush counter = 0.
  - Reset overrides every other input in that cycle, including mid-flush; the counter clears.
- Arithmetic: all additions are mod 2^32.
  - PCAddResult = PCResult + 4; 32'hFFFF_FFFC wraps to 32'h0000_0000.
  - BranchTarget = BranchBase + ({{14{BranchOffset[15]}}, BranchOffset, 2'b00}).
  - JumpTarget = {JumpBase[31:28], JumpIndex, 2'b00}.
  - JRTarget = {JumpRegTarget[31:2], 2'b00}.
- Redirect priority, evaluated in RUN only:
  - JumpReg first, then BranchTaken, then Jump.
  - EX-stage resolution is older than ID-stage decode, so JR and branch win over J.
- States:
  - RUN:
    - If any redirect request is high, the next edge loads PCResult = selected target, Flush = 1, counter = FLUSH_CYCLES-1, and the state goes to FLUSH.
    - A redirect overrides Stall.
    - Otherwise, Stall = 1 holds PCResult.
    - Otherwise, PCResult = PCAddResult.
  - FLUSH:
    - All redirect inputs are ignored, because they come from squashed instructions.
    - PCResult advances by 4 per cycle unless Stall = 1.
    - If counter == 0, the next edge sets Flush = 0 and the state goes to RUN. Otherwise the counter decrements and Flush stays 1.
    - Stall does not pause the counter.
- Flush latency:
  - Flush rises in the same cycle the redirected PC first appears on PCResult (one edge after the request).
  - Flush stays high for exactly FLUSH_CYCLES cycles.
- MisalignErr:
  - Set on the edge where a JR redirect is taken with JumpRegTarget[1:0] != 0.
  - Holds until Reset.
  - An ignored JR in FLUSH does not set it.
- Simultaneous requests: only the highest-priority request is taken; the rest are discarded with no side effects.
- A redirect in RUN on the cycle immediately after FLUSH returns to RUN is accepted normally (back-to-back redirects).

Test Plan:
- Reset then 4 idle cycles, RESET_PC = 0 -> PCResult 0, 4, 8, 12; PCAddResult always PCResult+4; Flush = 0.
- PC = 32'hFFFF_FFF8, no requests for 3 cycles -> PCResult FFFF_FFFC, 0000_0000, 0000_0004.
- BranchTaken = 1, BranchBase = 32'h0000_0100, BranchOffset = 16'hFFFE, Stall = 1 -> next PCResult = 32'h0000_00F8, Flush = 1 for 1 cycle (FLUSH_CYCLES = 1).
- JumpReg = 1 (JumpRegTarget = 32'h0000_2003), BranchTaken = 1 and Jump = 1 in the same cycle -> PCResult = 32'h0000_2000, MisalignErr = 1 and stays 1 until Reset.
- FLUSH_CYCLES = 3: Jump with JumpBase = 32'hA000_0000, JumpIndex = 26'h0000040 -> PCResult = 32'hA000_0100, Flush high 3 cycles; BranchTaken pulsed during the flush is ignored (PCResult 0104, 0108).
- Reset asserted during the second FLUSH cycle -> next edge PCResult = RESET_PC, Flush = 0, state RUN; a subsequent Jump is accepted normally.

Source files
------------

// File: rtl/pc_redirect_sequencer_if.sv
// Request/response bundle between the branch/jump resolution logic and the
// PC sequencer: redirect requests flow in, the fetch PC and flush flow out.
interface pc_redirect_sequencer_if;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchBase;
  logic [15:0] BranchOffset;
  logic        Jump;
  logic [31:0] JumpBase;
  logic [25:0] JumpIndex;
  logic        JumpReg;
  logic [31:0] JumpRegTarget;
  logic [31:0] PCResult;
  logic [31:0] PCAddResult;
  logic        Flush;
  logic        MisalignErr;

  modport master (
    output Stall, BranchTaken, BranchBase, BranchOffset,
           Jump, JumpBase, JumpIndex, JumpReg, JumpRegTarget,
    input  PCResult, PCAddResult, Flush, MisalignErr
  );

  modport slave (
    input  Stall, BranchTaken, BranchBase, BranchOffset,
           Jump, JumpBase, JumpIndex, JumpReg, JumpRegTarget,
    output PCResult, PCAddResult, Flush, MisalignErr
  );
endinterface

// File: rtl/pc_redirect_sequencer.sv
// Program counter owner: picks PC+4, branch, J/JAL or JR target each cycle
// and holds Flush high for a fixed window after every redirect.
module pc_redirect_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic                          Clk,
  input  logic                          Reset,
  pc_redirect_sequencer_if.slave        bus
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        flush_q, flush_d;
  logic        misalign_q, misalign_d;

  logic [31:0] pcAdd;
  logic [31:0] branchTarget;
  logic [31:0] jumpTarget;
  logic [31:0] jrTarget;

  assign pcAdd        = pc_q + 32'd4;
  assign branchTarget = bus.BranchBase + {{14{bus.BranchOffset[15]}}, bus.BranchOffset, 2'b00};
  assign jumpTarget   = {bus.JumpBase[31:28], bus.JumpIndex, 2'b00};
  assign jrTarget     = {bus.JumpRegTarget[31:2], 2'b00};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      cnt_q      <= 3'd0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

  // EX-stage resolutions (JR, branch) are older than ID-stage J, so they win;
  // in FLUSH every request comes from a squashed instruction and is dropped.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    flush_d    = flush_q;
    misalign_d = misalign_q;
    unique case (state_q)
      RUN: begin
        if (bus.JumpReg || bus.BranchTaken || bus.Jump) begin
          state_d = FLUSH;
          flush_d = 1'b1;
          cnt_d   = FLUSH_INIT;
          if (bus.JumpReg) begin
            pc_d = jrTarget;
            if (bus.JumpRegTarget[1:0] != 2'b00) begin
              misalign_d = 1'b1;
            end
          end else if (bus.BranchTaken) begin
            pc_d = branchTarget;
          end else begin
            pc_d = jumpTarget;
          end
        end else if (!bus.Stall) begin
          pc_d = pcAdd;
        end
      end
      FLUSH: begin
        if (!bus.Stall) begin
          pc_d = pcAdd;
        end
        if (cnt_q == 3'd0) begin
          flush_d = 1'b0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign bus.PCResult    = pc_q;
  assign bus.PCAddResult = pcAdd;
  assign bus.Flush       = flush_q;
  assign bus.MisalignErr = misalign_q;

endmodule

// File: tb/tb_pc_redirect_sequencer.sv
// Drives two sequencers (flush window 1 and 3) with identical stimulus and
// compares both against a remaining-flush-cycles reference model.
module tb_pc_redirect_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          N0       = 1;
  localparam int          N1       = 3;

  logic Clk;
  logic Reset;

  pc_redirect_sequencer_if bus0 ();
  pc_redirect_sequencer_if bus1 ();

  pc_redirect_sequencer #(.RESET_PC(RESET_PC), .FLUSH_CYCLES(N0)) dut0 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus0)
  );

  pc_redirect_sequencer #(.RESET_PC(RESET_PC), .FLUSH_CYCLES(N1)) dut1 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: PC, flush cycles still owed, sticky error
  logic [31:0] mPc   [2];
  int          mLeft [2];
  logic        mMis  [2];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic modelStep(input int i, input int n, input logic rst,
                           input logic stall, input logic bt,
                           input logic [31:0] bBase, input logic [15:0] bOff,
                           input logic jmp, input logic [31:0] jBase,
                           input logic [25:0] jIdx, input logic jr,
                           input logic [31:0] jrT);
    if (rst) begin
      mPc[i]   = RESET_PC;
      mLeft[i] = 0;
      mMis[i]  = 1'b0;
    end else if (mLeft[i] > 0) begin
      mLeft[i] = mLeft[i] - 1;
      if (!stall) mPc[i] = mPc[i] + 32'd4;
    end else if (jr) begin
      mPc[i]   = jrT & ~32'd3;
      mLeft[i] = n;
      if ((jrT % 4) != 0) mMis[i] = 1'b1;
    end else if (bt) begin
      mPc[i]   = bBase + 32'($signed(bOff)) * 32'd4;
      mLeft[i] = n;
    end else if (jmp) begin
      mPc[i]   = (jBase & 32'hF000_0000) + 32'(jIdx) * 32'd4;
      mLeft[i] = n;
    end else if (!stall) begin
      mPc[i] = mPc[i] + 32'd4;
    end
  endtask

  task automatic checkAll();
    checkOutput("pc0",    bus0.PCResult,          mPc[0]);
    checkOutput("pcadd0", bus0.PCAddResult,       mPc[0] + 32'd4);
    checkOutput("flush0", 32'(bus0.Flush),        32'(mLeft[0] > 0));
    checkOutput("mis0",   32'(bus0.MisalignErr),  32'(mMis[0]));
    checkOutput("pc1",    bus1.PCResult,          mPc[1]);
    checkOutput("pcadd1", bus1.PCAddResult,       mPc[1] + 32'd4);
    checkOutput("flush1", 32'(bus1.Flush),        32'(mLeft[1] > 0));
    checkOutput("mis1",   32'(bus1.MisalignErr),  32'(mMis[1]));
  endtask

  // Drive one cycle of inputs to both DUTs, clock, advance the model, check
  task automatic applyStimulus(input logic rst, input logic stall,
                               input logic bt, input logic [31:0] bBase,
                               input logic [15:0] bOff, input logic jmp,
                               input logic [31:0] jBase, input logic [25:0] jIdx,
                               input logic jr, input logic [31:0] jrT);
    Reset              = rst;
    bus0.Stall         = stall;  bus1.Stall         = stall;
    bus0.BranchTaken   = bt;     bus1.BranchTaken   = bt;
    bus0.BranchBase    = bBase;  bus1.BranchBase    = bBase;
    bus0.BranchOffset  = bOff;   bus1.BranchOffset  = bOff;
    bus0.Jump          = jmp;    bus1.Jump          = jmp;
    bus0.JumpBase      = jBase;  bus1.JumpBase      = jBase;
    bus0.JumpIndex     = jIdx;   bus1.JumpIndex     = jIdx;
    bus0.JumpReg       = jr;     bus1.JumpReg       = jr;
    bus0.JumpRegTarget = jrT;    bus1.JumpRegTarget = jrT;
    @(posedge Clk);
    modelStep(0, N0, rst, stall, bt, bBase, bOff, jmp, jBase, jIdx, jr, jrT);
    modelStep(1, N1, rst, stall, bt, bBase, bOff, jmp, jBase, jIdx, jr, jrT);
    #1;
    checkAll();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1'b0, 32'h0, 26'h0, 1'b0, 32'h0);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h1234_0000, 16'h0010, 1'b1,
                  32'h5000_0000, 26'h1, 1'b1, 32'h0000_0003);
  endtask

  initial begin
    Reset = 1'b1;
    mPc[0] = 32'h0; mPc[1] = 32'h0;
    mLeft[0] = 0;   mLeft[1] = 0;
    mMis[0] = 1'b0; mMis[1] = 1'b0;

    // Reset (with every request high) then sequential fetch 4, 8, 12
    doReset();
    checkOutput("rst_pc", bus0.PCResult, 32'h0000_0000);
    for (int k = 1; k <= 4; k++) begin
      idle();
      checkOutput("seq_pc", bus0.PCResult, 32'(k * 4));
    end

    // PC wrap at the top of the address space
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1'b0, 32'h0, 26'h0,
                  1'b1, 32'hFFFF_FFF8);
    checkOutput("wrap_start", bus0.PCResult, 32'hFFFF_FFF8);
    idle(); checkOutput("wrap_a", bus0.PCResult, 32'hFFFF_FFFC);
    checkOutput("wrap_add", bus0.PCAddResult, 32'h0000_0000);
    idle(); checkOutput("wrap_b", bus0.PCResult, 32'h0000_0000);
    idle(); checkOutput("wrap_c", bus0.PCResult, 32'h0000_0004);

    // Backward branch overrides Stall
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0100, 16'hFFFE, 1'b0, 32'h0, 26'h0,
                  1'b0, 32'h0);
    checkOutput("br_pc", bus0.PCResult, 32'h0000_00F8);
    checkOutput("br_flush", 32'(bus0.Flush), 32'd1);
    idle();
    checkOutput("br_flush_end", 32'(bus0.Flush), 32'd0);

    // JR beats branch and J; misaligned target sets sticky error
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0400, 16'h0004, 1'b1,
                  32'h3000_0000, 26'h10, 1'b1, 32'h0000_2003);
    checkOutput("jr_pc", bus0.PCResult, 32'h0000_2000);
    checkOutput("jr_mis", 32'(bus0.MisalignErr), 32'd1);
    for (int k = 0; k < 4; k++) idle();
    checkOutput("jr_mis_hold", 32'(bus1.MisalignErr), 32'd1);

    // Three-cycle flush window; branch during flush is ignored
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1'b1, 32'hA000_0000, 26'h0000040,
                  1'b0, 32'h0);
    checkOutput("j_pc", bus1.PCResult, 32'hA000_0100);
    checkOutput("j_flush", 32'(bus1.Flush), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_8000, 16'h0040, 1'b0, 32'h0, 26'h0,
                  1'b1, 32'h0000_0001);
    checkOutput("j_ign_pc", bus1.PCResult, 32'hA000_0104);
    checkOutput("j_ign_mis", 32'(bus1.MisalignErr), 32'd0);
    idle(); checkOutput("j_pc2", bus1.PCResult, 32'hA000_0108);
    checkOutput("j_flush2", 32'(bus1.Flush), 32'd1);
    idle(); checkOutput("j_flush_end", 32'(bus1.Flush), 32'd0);

    // Reset mid-flush, then a fresh jump is accepted
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1'b1, 32'h4000_0000, 26'h3,
                  1'b0, 32'h0);
    idle();
    doReset();
    checkOutput("mid_rst_flush", 32'(bus1.Flush), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1'b1, 32'h4000_0000, 26'h3,
                  1'b0, 32'h0);
    checkOutput("mid_rst_j", bus1.PCResult, 32'h4000_000C);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(($urandom_range(0, 99) < 2),
                    ($urandom_range(0, 99) < 25),
                    ($urandom_range(0, 99) < 12), $urandom, 16'($urandom),
                    ($urandom_range(0, 99) < 12), $urandom, 26'($urandom),
                    ($urandom_range(0, 99) < 8), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
